// File: rtl/lsu_mem_port_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// slave: the LSU's view. master: the CPU execute stage plus the memory.
interface lsu_mem_port_if #(
  parameter int XLEN = 32
);
  localparam int BYTES = XLEN / 8;

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;

  logic             rsp_valid;
  logic [XLEN-1:0]  rsp_rdata;
  logic             rsp_fault;

  logic             mem_r;
  logic [BYTES-1:0] mem_w;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_din;
  logic [XLEN-1:0]  mem_dout;
  logic             mem_ready;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_dout, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_r, mem_w, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_dout, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_r, mem_w, mem_addr, mem_din
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit: turns one CPU load/store into one or two byte-lane
// memory beats, with sign/zero extension and misalignment handling.
module lsu_mem_port #(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input logic           clk,
  input logic           rstn,
  lsu_mem_port_if.slave bus
);
  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFF   = $clog2(BYTES);
  localparam int unsigned MW    = 2 * BYTES;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state;

  // latched request
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [OFF-1:0]    off_q;
  logic              cross_q;
  logic [BYTES-1:0]  mask_hi_q;
  logic [XLEN-1:0]   wsh_hi_q;
  logic [XLEN-1:0]   beat0_q;

  // registered outputs
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              rsp_fault_q;
  logic              mem_r_q;
  logic [BYTES-1:0]  mem_w_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic [XLEN-1:0]   mem_din_q;

  // request decode
  int unsigned       off_i;
  int unsigned       nb_i;
  logic              req_cross;
  logic              req_misal;
  logic              req_fault;
  logic [MW-1:0]     req_mask;
  logic [2*XLEN-1:0] req_wsh;

  // load assembly
  logic [2*XLEN-1:0] raw;
  logic [XLEN-1:0]   sh;
  int unsigned       nbq;
  logic              sign;
  logic [XLEN-1:0]   ld_data;

  // Decode the offered request: byte mask over two beats, shifted store data, fault.
  always_comb begin
    off_i     = 32'(bus.req_addr[OFF-1:0]);
    nb_i      = 32'd1 << bus.req_size;
    req_cross = (off_i + nb_i) > BYTES;
    req_misal = (off_i & (nb_i - 32'd1)) != 32'd0;
    req_fault = ((XLEN == 32) && (bus.req_size == 2'd3)) ||
                (!SPLIT_MISALIGNED && req_misal);
    req_mask  = '0;
    for (int unsigned i = 0; i < MW; i++)
      req_mask[i] = (i >= off_i) && (i < off_i + nb_i);
    req_wsh   = {{XLEN{1'b0}}, bus.req_wdata} << (8 * off_i);
  end

  // Join the beats, shift the addressed bytes down, then extend to XLEN.
  always_comb begin
    raw  = (state == BEAT1) ? {bus.mem_dout, beat0_q} : {{XLEN{1'b0}}, bus.mem_dout};
    sh   = XLEN'(raw >> {off_q, 3'b000});
    nbq  = 32'd1 << size_q;
    sign = 1'b0;
    for (int unsigned i = 0; i < BYTES; i++)
      if (i == nbq - 32'd1) sign = sh[8*i+7];
    ld_data = '0;
    for (int unsigned i = 0; i < BYTES; i++)
      ld_data[8*i +: 8] = (i < nbq) ? sh[8*i +: 8] : {8{sign & ~uns_q}};
  end

  // Control FSM; every bus/response output is registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      cross_q     <= 1'b0;
      mask_hi_q   <= '0;
      wsh_hi_q    <= '0;
      beat0_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      mem_r_q     <= 1'b0;
      mem_w_q     <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= bus.req_we;
            size_q      <= bus.req_size;
            uns_q       <= bus.req_unsigned;
            off_q       <= bus.req_addr[OFF-1:0];
            cross_q     <= req_cross;
            mask_hi_q   <= req_mask[MW-1:BYTES];
            wsh_hi_q    <= req_wsh[2*XLEN-1:XLEN];
            if (req_fault) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state      <= BEAT0;
              mem_addr_q <= bus.req_addr & ~XLEN'(BYTES - 1);
              mem_r_q    <= !bus.req_we;
              mem_w_q    <= bus.req_we ? req_mask[BYTES-1:0] : '0;
              mem_din_q  <= bus.req_we ? req_wsh[XLEN-1:0] : '0;
            end
          end
        end
        BEAT0: begin
          if (bus.mem_ready) begin
            beat0_q <= bus.mem_dout;
            if (cross_q) begin
              state      <= BEAT1;
              mem_addr_q <= mem_addr_q + XLEN'(BYTES);
              mem_w_q    <= we_q ? mask_hi_q : '0;
              mem_din_q  <= we_q ? wsh_hi_q : '0;
            end else begin
              state       <= RESP;
              mem_r_q     <= 1'b0;
              mem_w_q     <= '0;
              mem_addr_q  <= '0;
              mem_din_q   <= '0;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b0;
              rsp_rdata_q <= we_q ? '0 : ld_data;
            end
          end
        end
        BEAT1: begin
          if (bus.mem_ready) begin
            state       <= RESP;
            mem_r_q     <= 1'b0;
            mem_w_q     <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : ld_data;
          end
        end
        RESP: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_fault_q <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.mem_r     = mem_r_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: XLEN=32 split, XLEN=64 split, XLEN=32 fault-only.
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rdy32 = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  lsu_mem_port_if #(.XLEN(32)) b32 ();
  lsu_mem_port_if #(.XLEN(64)) b64 ();
  lsu_mem_port_if #(.XLEN(32)) b0 ();

  lsu_mem_port #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) u32  (.clk(clk), .rstn(rstn), .bus(b32));
  lsu_mem_port #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) u64  (.clk(clk), .rstn(rstn), .bus(b64));
  lsu_mem_port #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) u32f (.clk(clk), .rstn(rstn), .bus(b0));

  // 32-bit memory: 16 words, byte-writable
  logic [31:0] m32 [16] = '{default: 32'h0};
  assign b32.mem_dout  = m32[b32.mem_addr[5:2]];
  assign b32.mem_ready = rdy32;
  always @(posedge clk)
    if (rdy32)
      for (int i = 0; i < 4; i++)
        if (b32.mem_w[i]) m32[b32.mem_addr[5:2]][8*i +: 8] <= b32.mem_din[8*i +: 8];

  // 64-bit memory: fixed read-only contents
  assign b64.mem_dout  = (b64.mem_addr == 64'h0) ? 64'h80000001_A0B0C0D0 :
                         (b64.mem_addr == 64'hFFFF_FFFF_FFFF_FFF8) ? 64'h11223344_55667788 : 64'h0;
  assign b64.mem_ready = 1'b1;

  assign b0.mem_dout  = 32'h12345678;
  assign b0.mem_ready = 1'b1;

  function automatic logic rdy_of(input int unsigned which);
    case (which)
      0: rdy_of = b32.req_ready;
      1: rdy_of = b64.req_ready;
      default: rdy_of = b0.req_ready;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic issue(input int unsigned which, input logic we, input logic [1:0] size,
                       input logic uns, input logic [63:0] addr, input logic [63:0] wdata);
    int unsigned n = 0;
    while (!rdy_of(which) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy_of(which)) begin
      errors++;
      $display("FAIL issue_timeout: req_ready=0 after %0d cycles, required 1", n);
    end
    case (which)
      0: begin
        b32.req_we = we; b32.req_size = size; b32.req_unsigned = uns;
        b32.req_addr = addr[31:0]; b32.req_wdata = wdata[31:0]; b32.req_valid = 1'b1;
      end
      1: begin
        b64.req_we = we; b64.req_size = size; b64.req_unsigned = uns;
        b64.req_addr = addr; b64.req_wdata = wdata; b64.req_valid = 1'b1;
      end
      default: begin
        b0.req_we = we; b0.req_size = size; b0.req_unsigned = uns;
        b0.req_addr = addr[31:0]; b0.req_wdata = wdata[31:0]; b0.req_valid = 1'b1;
      end
    endcase
    @(posedge clk);
    #1;
    b32.req_valid = 1'b0;
    b64.req_valid = 1'b0;
    b0.req_valid  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (b32.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", b32.req_ready); end
    checks++; if (b64.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready64: got %b want 0", b64.req_ready); end
    checks++; if (b32.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %b want 0", b32.rsp_valid); end
    checks++; if ({b32.mem_r, b32.mem_w} !== 5'b0) begin errors++; $display("FAIL rst_strobes: got %b want 0", {b32.mem_r, b32.mem_w}); end
    checks++; if (b32.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", b32.mem_addr); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (b32.req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", b32.req_ready); end
  endtask

  task automatic test_byte();
    issue(0, 1'b1, 2'd0, 1'b0, 64'h0, 64'd132);
    checks++; if (b32.mem_w !== 4'b0001) begin errors++; $display("FAIL sb_mem_w: got %b want 0001", b32.mem_w); end
    checks++; if (b32.mem_din[7:0] !== 8'h84) begin errors++; $display("FAIL sb_din: got %h want 84", b32.mem_din[7:0]); end
    checks++; if (b32.rsp_valid !== 1'b0) begin errors++; $display("FAIL sb_early_rsp: got %b want 0", b32.rsp_valid); end
    @(negedge clk);
    checks++; if ({b32.rsp_valid, b32.rsp_fault} !== 2'b10) begin errors++; $display("FAIL sb_rsp: got %b want 10", {b32.rsp_valid, b32.rsp_fault}); end
    issue(0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
    checks++; if (b32.mem_r !== 1'b1) begin errors++; $display("FAIL lb_mem_r: got %b want 1", b32.mem_r); end
    @(negedge clk);
    checks++; if (!(b32.rsp_valid === 1'b1 && b32.rsp_rdata === 32'hFFFFFF84)) begin errors++; $display("FAIL lb_rdata: got v=%b %h want 1 FFFFFF84", b32.rsp_valid, b32.rsp_rdata); end
    issue(0, 1'b0, 2'd0, 1'b1, 64'h0, 64'h0);
    @(negedge clk);
    checks++; if (!(b32.rsp_valid === 1'b1 && b32.rsp_rdata === 32'h00000084)) begin errors++; $display("FAIL lbu_rdata: got v=%b %h want 1 00000084", b32.rsp_valid, b32.rsp_rdata); end
  endtask

  task automatic test_crossing();
    issue(0, 1'b1, 2'd1, 1'b0, 64'h3, 64'hBEEF);
    checks++; if (!(b32.mem_addr === 32'h0 && b32.mem_w === 4'b1000 && b32.mem_din[31:24] === 8'hEF)) begin
      errors++; $display("FAIL sh_beat0: got a=%h w=%b d=%h want 0 1000 EF", b32.mem_addr, b32.mem_w, b32.mem_din[31:24]); end
    @(negedge clk);
    checks++; if (!(b32.mem_addr === 32'h4 && b32.mem_w === 4'b0001 && b32.mem_din[7:0] === 8'hBE && b32.rsp_valid === 1'b0)) begin
      errors++; $display("FAIL sh_beat1: got a=%h w=%b d=%h v=%b want 4 0001 BE 0", b32.mem_addr, b32.mem_w, b32.mem_din[7:0], b32.rsp_valid); end
    @(negedge clk);
    checks++; if (b32.rsp_valid !== 1'b1) begin errors++; $display("FAIL sh_rsp: got %b want 1", b32.rsp_valid); end
    issue(0, 1'b0, 2'd1, 1'b0, 64'h3, 64'h0);
    @(negedge clk);
    checks++; if (b32.rsp_valid !== 1'b0) begin errors++; $display("FAIL lh_early: got %b want 0", b32.rsp_valid); end
    @(negedge clk);
    checks++; if (!(b32.rsp_valid === 1'b1 && b32.rsp_rdata === 32'hFFFFBEEF)) begin errors++; $display("FAIL lh_cross: got v=%b %h want 1 FFFFBEEF", b32.rsp_valid, b32.rsp_rdata); end
    // half at offset 1 does not cross: single beat
    issue(0, 1'b1, 2'd1, 1'b0, 64'h1, 64'h8001);
    checks++; if (!(b32.mem_w === 4'b0110 && b32.mem_din[23:8] === 16'h8001)) begin errors++; $display("FAIL sh1_beat: got w=%b d=%h want 0110 8001", b32.mem_w, b32.mem_din[23:8]); end
    issue(0, 1'b0, 2'd1, 1'b0, 64'h1, 64'h0);
    @(negedge clk);
    checks++; if (!(b32.rsp_valid === 1'b1 && b32.rsp_rdata === 32'hFFFF8001)) begin errors++; $display("FAIL lh1: got v=%b %h want 1 FFFF8001", b32.rsp_valid, b32.rsp_rdata); end
  endtask

  task automatic test_xlen64();
    issue(1, 1'b0, 2'd2, 1'b1, 64'h4, 64'h0);
    checks++; if (!(b64.mem_r === 1'b1 && b64.mem_addr === 64'h0)) begin errors++; $display("FAIL lwu64_beat: got r=%b a=%h want 1 0", b64.mem_r, b64.mem_addr); end
    @(negedge clk);
    checks++; if (!(b64.rsp_valid === 1'b1 && b64.rsp_rdata === 64'h0000000080000001)) begin errors++; $display("FAIL lwu64: got v=%b %h want 1 0000000080000001", b64.rsp_valid, b64.rsp_rdata); end
    issue(1, 1'b0, 2'd2, 1'b0, 64'h4, 64'h0);
    @(negedge clk);
    checks++; if (b64.rsp_rdata !== 64'hFFFFFFFF80000001) begin errors++; $display("FAIL lw64: got %h want FFFFFFFF80000001", b64.rsp_rdata); end
    issue(1, 1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    checks++; if (b64.mem_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL ld_wrap_b0: got %h want FFFFFFFFFFFFFFF8", b64.mem_addr); end
    @(negedge clk);
    checks++; if (!(b64.mem_addr === 64'h0 && b64.mem_r === 1'b1)) begin errors++; $display("FAIL ld_wrap_b1: got a=%h r=%b want 0 1", b64.mem_addr, b64.mem_r); end
    @(negedge clk);
    checks++; if (!(b64.rsp_valid === 1'b1 && b64.rsp_rdata === 64'hA0B0C0D0_11223344)) begin errors++; $display("FAIL ld_wrap: got v=%b %h want 1 A0B0C0D011223344", b64.rsp_valid, b64.rsp_rdata); end
  endtask

  task automatic test_wait_states();
    rdy32 = 1'b0;
    issue(0, 1'b1, 2'd2, 1'b0, 64'h8, 64'hCAFEF00D);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (!(b32.mem_addr === 32'h8 && b32.mem_w === 4'b1111 && b32.mem_din === 32'hCAFEF00D && b32.rsp_valid === 1'b0)) begin
        errors++; $display("FAIL wait_hold_T%0d: got a=%h w=%b d=%h v=%b want 8 1111 CAFEF00D 0", k, b32.mem_addr, b32.mem_w, b32.mem_din, b32.rsp_valid); end
      if (k == 4) rdy32 = 1'b1;
      @(negedge clk);
    end
    checks++; if (b32.rsp_valid !== 1'b1) begin errors++; $display("FAIL wait_rsp_T5: got %b want 1", b32.rsp_valid); end
    @(negedge clk);
    checks++; if (b32.rsp_valid !== 1'b0) begin errors++; $display("FAIL wait_single_pulse: got %b want 0", b32.rsp_valid); end
    issue(0, 1'b0, 2'd2, 1'b0, 64'h8, 64'h0);
    @(negedge clk);
    checks++; if (b32.rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL wait_readback: got %h want CAFEF00D", b32.rsp_rdata); end
  endtask

  task automatic test_fault();
    issue(2, 1'b0, 2'd2, 1'b0, 64'h2, 64'h0);
    checks++; if (!(b0.rsp_valid === 1'b1 && b0.rsp_fault === 1'b1 && b0.rsp_rdata === 32'h0)) begin
      errors++; $display("FAIL lw_misal: got v=%b f=%b %h want 1 1 0", b0.rsp_valid, b0.rsp_fault, b0.rsp_rdata); end
    checks++; if ({b0.mem_r, b0.mem_w} !== 5'b0) begin errors++; $display("FAIL lw_misal_bus: got %b want 0", {b0.mem_r, b0.mem_w}); end
    @(negedge clk);
    checks++; if (b0.rsp_valid !== 1'b0) begin errors++; $display("FAIL fault_pulse: got %b want 0", b0.rsp_valid); end
    issue(2, 1'b0, 2'd1, 1'b0, 64'h1, 64'h0);
    checks++; if (b0.rsp_fault !== 1'b1) begin errors++; $display("FAIL lh1_nosplit: got %b want 1", b0.rsp_fault); end
    issue(2, 1'b0, 2'd2, 1'b0, 64'h4, 64'h0);
    @(negedge clk);
    checks++; if (!(b0.rsp_valid === 1'b1 && b0.rsp_fault === 1'b0 && b0.rsp_rdata === 32'h12345678)) begin
      errors++; $display("FAIL lw_aligned_nosplit: got v=%b f=%b %h want 1 0 12345678", b0.rsp_valid, b0.rsp_fault, b0.rsp_rdata); end
    issue(0, 1'b0, 2'd3, 1'b0, 64'h0, 64'h0);
    checks++; if (!(b32.rsp_valid === 1'b1 && b32.rsp_fault === 1'b1 && b32.mem_r === 1'b0)) begin
      errors++; $display("FAIL size3_x32: got v=%b f=%b r=%b want 1 1 0", b32.rsp_valid, b32.rsp_fault, b32.mem_r); end
  endtask

  task automatic test_reset_midflight();
    issue(0, 1'b1, 2'd2, 1'b0, 64'h6, 64'h55667788);
    checks++; if (!(b32.mem_addr === 32'h4 && b32.mem_w === 4'b1100 && b32.mem_din[31:16] === 16'h7788)) begin
      errors++; $display("FAIL sw_cross_b0: got a=%h w=%b d=%h want 4 1100 7788", b32.mem_addr, b32.mem_w, b32.mem_din[31:16]); end
    @(negedge clk);
    checks++; if (!(b32.mem_addr === 32'h8 && b32.mem_w === 4'b0011)) begin errors++; $display("FAIL sw_cross_b1: got a=%h w=%b want 8 0011", b32.mem_addr, b32.mem_w); end
    rstn = 1'b0;
    #1;
    checks++; if (!(b32.mem_w === 4'b0 && b32.req_ready === 1'b0 && b32.mem_addr === 32'h0)) begin
      errors++; $display("FAIL async_rst: got w=%b rdy=%b a=%h want 0 0 0", b32.mem_w, b32.req_ready, b32.mem_addr); end
    @(negedge clk);
    checks++; if (b32.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: got %b want 0", b32.rsp_valid); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (!(b32.req_ready === 1'b1 && b32.rsp_valid === 1'b0)) begin errors++; $display("FAIL rst_release: got rdy=%b v=%b want 1 0", b32.req_ready, b32.rsp_valid); end
    issue(0, 1'b0, 2'd2, 1'b0, 64'h8, 64'h0);
    @(negedge clk);
    checks++; if (!(b32.rsp_valid === 1'b1 && b32.rsp_rdata === 32'hCAFEF00D)) begin errors++; $display("FAIL beat1_abandoned: got v=%b %h want 1 CAFEF00D", b32.rsp_valid, b32.rsp_rdata); end
    issue(0, 1'b0, 2'd2, 1'b0, 64'h4, 64'h0);
    @(negedge clk);
    checks++; if (b32.rsp_rdata !== 32'h778800BE) begin errors++; $display("FAIL beat0_kept: got %h want 778800BE", b32.rsp_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_size = '0; b32.req_unsigned = 1'b0;
    b32.req_addr = '0; b32.req_wdata = '0;
    b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_size = '0; b64.req_unsigned = 1'b0;
    b64.req_addr = '0; b64.req_wdata = '0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_size = '0; b0.req_unsigned = 1'b0;
    b0.req_addr = '0; b0.req_wdata = '0;
    test_reset();
    test_byte();
    test_crossing();
    test_xlen64();
    test_wait_states();
    test_fault();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Parametrised load/store unit between the CPU execute stage and the byte-addressed data memory port (`mem_r`, `mem_w`, `mem_addr`, `mem_din`, `mem_dout`).
- Generalises the fixed-width byte-store/load path to any XLEN (32 or 64), all access sizes and sign/zero extension, and memory wait states.
- Misaligned accesses that cross a word boundary are either split into two bus beats or reported as a fault, selected by parameter.

Parameters:
- XLEN, 32, data/address width; 32 or 64. BYTES = XLEN/8, OFF = log2(BYTES).
- SPLIT_MISALIGNED, 1, 1: split word-crossing accesses into two beats; 0: any non-size-aligned access faults.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (double legal only when XLEN=64).
- req_unsigned  in  1  zero-extend load result (lbu/lhu/lwu).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse; result/completion.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- rsp_fault  out  1  valid with rsp_valid; misaligned or illegal size.
- mem_r  out  1  read strobe.
- mem_w  out  BYTES  per-byte write enables.
- mem_addr  out  XLEN  BYTES-aligned beat address.
- mem_din  out  XLEN  write data, lane-aligned.
- mem_dout  in  XLEN  read data, valid combinationally in the same cycle as mem_r.
- mem_ready  in  1  beat completes at the rising edge when high.

Behaviour:
- Reset (rstn low, async): state IDLE.
  - All outputs 0, including req_ready.
  - Any in-flight beat is abandoned; no partial write is completed after rstn falls.
  - Already-committed beat0 writes are not undone.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - Fault check: req_size=3 with XLEN=32, or misaligned with SPLIT_MISALIGNED=0 -> RESP with fault set.
  - Otherwise -> BEAT0.
- Derived values:
  - nbytes = 1 << size; off = addr[OFF-1:0].
  - mask = ((1 << nbytes) - 1) << off, width 2*BYTES.
  - crossing = (off + nbytes > BYTES).
- BEAT0:
  - mem_addr = {addr[XLEN-1:OFF], OFF'b0}.
  - Store: mem_w = mask[BYTES-1:0], mem_din = (wdata << 8*off) low half.
  - Load: mem_r=1.
  - Hold outputs stable until mem_ready.
  - On mem_ready: capture mem_dout lanes, then -> BEAT1 if crossing, else RESP.
- BEAT1:
  - mem_addr = beat0 address + BYTES, modulo 2^XLEN (wraps at top of address space).
  - mem_w = mask[2*BYTES-1:BYTES]; mem_din = upper half of the shifted wdata.
  - On mem_ready -> RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - Load: rsp_rdata = assembled bytes >> 8*off, truncated to nbytes, then sign- or zero-extended.
  - Then -> IDLE.
- Outside BEAT0/BEAT1: mem_r=0, mem_w=0, mem_addr=0, mem_din=0.
- Latency with mem_ready=1, request accepted at edge T:
  - BEAT0 in cycle T+1.
  - rsp_valid in cycle T+2 (aligned or non-crossing), T+3 (crossing), T+1 (fault).
- Each wait cycle (mem_ready=0) adds one cycle.
- New requests are not accepted while busy (no pipelining); req_valid held in a busy state is ignored until IDLE.
- Word-aligned but non-size-aligned access that does not cross (e.g. half at offset 1) is a single beat when SPLIT_MISALIGNED=1.

Test Plan:
- XLEN=32, store byte 132 @0x0 then load byte @0x0 -> mem_w=4'b0001, mem_din[7:0]=0x84; lb rsp_rdata=0xFFFFFF84, lbu rsp_rdata=0x00000084, each rsp at T+2.
- XLEN=32, store half 0xBEEF @0x3 -> beat0 addr 0x0, mem_w=4'b1000, mem_din[31:24]=0xEF; beat1 addr 0x4, mem_w=4'b0001, mem_din[7:0]=0xBE; lh @0x3 returns 0xFFFFBEEF at T+3.
- XLEN=64, load word unsigned @0x4 holding 0x80000001 -> one beat, mem_addr 0x0, rsp_rdata=0x0000000080000001; ld @0xFFFFFFFFFFFFFFFC wraps beat1 to 0x0.
- Wait states: mem_ready low for 3 cycles on beat0 of an aligned sw -> mem_addr/mem_w/mem_din stable throughout, rsp_valid at T+5, exactly one pulse.
- SPLIT_MISALIGNED=0: lw @0x2 -> no mem_r/mem_w activity, rsp_fault=1, rsp_rdata=0 at T+1; size=3 on XLEN=32 faults likewise.
- Drop rstn during a crossing store's BEAT1 -> mem_w=0 and req_ready=0 immediately, no rsp_valid; after release req_ready=1 and next aligned lw completes normally.
